// File: rtl/rs544_parity_enc.sv
// RS(544,522) systematic parity encoder over GF(2^10), 32 symbols per beat.
// Each frame is 17 beats: 16 full message beats, then 10 message symbols and 22 parity symbols.

module gf1024_mul_pb_k5_flat (
    input  logic [9:0] a_i,
    input  logic [9:0] b_i,
    output logic [9:0] p_o
);
    logic [18:0] prod;

    always_comb begin
        prod = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (b_i[i]) prod = prod ^ (19'(a_i) << i);
        end
        // Fold x^18..x^10 back using x^10 = x^3 + 1
        for (int unsigned k = 18; k >= 10; k--) begin
            if (prod[k]) prod = prod ^ (19'(11'h409) << (k - 10));
        end
        p_o = prod[9:0];
    end
endmodule

module rs544_parity_enc (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             sof_i,
    input  logic [31:0][9:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0][9:0] data_o,
    output logic             sof_o,
    output logic             last_o,
    output logic             err_o
);
    function automatic logic [9:0] gf_mul_c(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] acc;
        logic [9:0] sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < 10; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[9] ? ((sh << 1) ^ 10'h009) : (sh << 1);
        end
        return acc;
    endfunction

    // Low 22 coefficients of the monic g(x) = prod_{j=1..22} (x + alpha^j)
    function automatic logic [21:0][9:0] gen_poly();
        logic [22:0][9:0] g;
        logic [9:0]       root;
        g    = '0;
        g[0] = 10'd1;
        root = 10'd1;
        for (int unsigned j = 1; j <= 22; j++) begin
            root = gf_mul_c(root, 10'd2);
            for (int unsigned d = j; d >= 1; d--) begin
                g[d] = g[d-1] ^ gf_mul_c(g[d], root);
            end
            g[0] = gf_mul_c(g[0], root);
        end
        return g[21:0];
    endfunction

    localparam logic [21:0][9:0] GEN = gen_poly();

    logic [4:0]       bc;
    logic [21:0][9:0] rem;
    logic [21:0][9:0] rem_start;
    logic [21:0][9:0] rem_full;
    logic [21:0][9:0] parity;
    logic [31:0][9:0] data_nxt;
    logic [4:0]       eff_bc;
    logic             accept;
    logic             is_last;
    logic             frame_err;

    assign ready_o   = ready_i || !valid_o;
    assign accept    = valid_i && ready_o;
    assign eff_bc    = sof_i ? 5'd0 : bc;
    assign is_last   = (eff_bc == 5'd16);
    assign frame_err = sof_i ? (bc != 5'd0) : (bc == 5'd0);
    assign rem_start = (eff_bc == 5'd0) ? '0 : rem;

    // Unrolled LFSR: lane l absorbs data_i[l] into the remainder left by lane l-1
    for (genvar l = 0; l < 32; l++) begin : g_lane
        logic [21:0][9:0] r_in;
        logic [21:0][9:0] r_out;
        logic [9:0]       fb;
        logic [9:0]       p [22];

        if (l == 0) begin : g_first
            assign r_in = rem_start;
        end else begin : g_next
            assign r_in = g_lane[l-1].r_out;
        end

        assign fb = data_i[l] ^ r_in[21];

        for (genvar i = 0; i < 22; i++) begin : g_tap
            gf1024_mul_pb_k5_flat u_mul (
                .a_i (fb),
                .b_i (GEN[i]),
                .p_o (p[i])
            );
        end

        always_comb begin
            r_out[0] = p[0];
            for (int unsigned i = 1; i < 22; i++) begin
                r_out[i] = r_in[i-1] ^ p[i];
            end
        end
    end

    assign rem_full = g_lane[31].r_out;
    assign parity   = g_lane[9].r_out;

    always_comb begin
        data_nxt = data_i;
        if (is_last) begin
            for (int unsigned k = 0; k < 22; k++) begin
                data_nxt[10+k] = parity[21-k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bc      <= '0;
            rem     <= '0;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            last_o  <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            err_o <= 1'b0;
            if (accept) begin
                bc      <= is_last ? 5'd0 : eff_bc + 5'd1;
                rem     <= is_last ? '0 : rem_full;
                valid_o <= 1'b1;
                sof_o   <= (eff_bc == 5'd0);
                last_o  <= is_last;
                err_o   <= frame_err;
                data_o  <= data_nxt;
            end else if (ready_i) begin
                valid_o <= 1'b0;
                sof_o   <= 1'b0;
                last_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs544_parity_enc.sv
// Scoreboard bench for rs544_parity_enc: table-based GF model, long-division parity, syndrome checks.

module tb_rs544_parity_enc;
    logic             clk = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             sof_i;
    logic [31:0][9:0] data_i;
    logic             ready_o;
    logic             valid_o;
    logic             ready_i;
    logic [31:0][9:0] data_o;
    logic             sof_o;
    logic             last_o;
    logic             err_o;

    always #5 clk = ~clk;

    rs544_parity_enc dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .sof_i   (sof_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .sof_o   (sof_o),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    typedef struct {
        logic [31:0][9:0] data;
        logic             sof;
        logic             last;
    } beat_t;

    beat_t            exp_q [$];
    logic [9:0]       rx_sym [$];
    int               n_tests = 0;
    int               n_fail = 0;
    int               err_seen = 0;
    bit               rdy_rand = 1'b0;
    bit               rx_en = 1'b0;
    int               exp_t [1023];
    int               log_t [1024];
    logic [9:0]       gfull [23];
    logic [9:0]       msg [522];
    logic [9:0]       cw [544];
    logic [31:0][9:0] last_rx;

    function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b);
        if (a == 10'd0 || b == 10'd0) return 10'd0;
        return 10'(exp_t[(log_t[a] + log_t[b]) % 1023]);
    endfunction

    function automatic void make_cw();
        logic [9:0] r [544];
        logic [9:0] coef;
        for (int i = 0; i < 544; i++) r[i] = (i < 522) ? msg[i] : 10'd0;
        for (int i = 0; i < 522; i++) begin
            coef = r[i];
            if (coef != 10'd0)
                for (int j = 1; j <= 22; j++) r[i+j] = r[i+j] ^ gmul(coef, gfull[22-j]);
        end
        for (int i = 0; i < 544; i++) cw[i] = (i < 522) ? msg[i] : r[i];
    endfunction

    always @(negedge clk) ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    // Output monitor: pops the scoreboard on each handshake and checks hold during stalls
    logic             prev_stall = 1'b0;
    logic [31:0][9:0] prev_d;
    logic             prev_sof;
    logic             prev_last;
    beat_t            mon_e;
    always begin
        @(negedge clk);
        #3;
        if (err_o === 1'b1) err_seen++;
        if (prev_stall && rst_ni) begin
            n_tests++;
            if (valid_o !== 1'b1 || data_o !== prev_d || sof_o !== prev_sof || last_o !== prev_last) begin
                n_fail++;
                $display("FAIL stall_hold: valid_o=%b sof=%b last=%b data changed=%b, required held beat",
                         valid_o, sof_o, last_o, data_o !== prev_d);
            end
        end
        if (rst_ni && valid_o === 1'b1 && ready_i === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: sof=%b last=%b, required no output", sof_o, last_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_o !== mon_e.data || sof_o !== mon_e.sof || last_o !== mon_e.last) begin
                    n_fail++;
                    $display("FAIL out_beat: sof=%b last=%b lane0=%h lane31=%h, required sof=%b last=%b lane0=%h lane31=%h",
                             sof_o, last_o, data_o[0], data_o[31], mon_e.sof, mon_e.last, mon_e.data[0], mon_e.data[31]);
                end
            end
            if (last_o === 1'b1) last_rx = data_o;
            if (rx_en) for (int l = 0; l < 32; l++) rx_sym.push_back(data_o[l]);
        end
        prev_stall = rst_ni && valid_o === 1'b1 && ready_i === 1'b0;
        prev_d     = data_o;
        prev_sof   = sof_o;
        prev_last  = last_o;
    end

    task automatic send_beat(input logic [31:0][9:0] d, input logic s, input beat_t e);
        bit done = 1'b0;
        @(negedge clk);
        valid_i = 1'b1;
        sof_i   = s;
        data_i  = d;
        for (int t = 0; t < 1000 && !done; t++) begin
            #2;
            if (ready_o === 1'b1) begin
                exp_q.push_back(e);
                done = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: ready_o=%b, required 1 within 1000 cycles", ready_o);
        end
    endtask

    task automatic send_frame(input bit first_sof, input bit exp_err);
        beat_t            e;
        logic [31:0][9:0] d;
        make_cw();
        for (int b = 0; b < 17; b++) begin
            for (int l = 0; l < 32; l++) begin
                e.data[l] = cw[32*b + l];
                if (b < 16 || l < 10) d[l] = msg[32*b + l];
                else                  d[l] = 10'($urandom);
            end
            e.sof  = (b == 0);
            e.last = (b == 16);
            send_beat(d, (b == 0) ? first_sof : 1'b0, e);
            if (b == 0) begin
                #1;
                n_tests++;
                if (err_o !== exp_err) begin
                    n_fail++;
                    $display("FAIL err_after_first_beat: err_o=%b, required %b", err_o, exp_err);
                end
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        valid_i = 1'b0;
        sof_i   = 1'b0;
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        #4;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic rand_msg();
        for (int i = 0; i < 522; i++) msg[i] = 10'($urandom);
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        data_i  = '0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || sof_o !== 1'b0 || last_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b sof=%b last=%b err=%b, required 0000", valid_o, sof_o, last_o, err_o);
        end
        n_tests++;
        if (data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: lane0=%h, required all zero", data_o[0]);
        end
        n_tests++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: ready_o=%b, required 1", ready_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_zero_frame();
        int e0 = err_seen;
        for (int i = 0; i < 522; i++) msg[i] = 10'd0;
        send_frame(1'b1, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        #4;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_latency: %0d beats pending one cycle after last accept, required 0", exp_q.size());
        end
        drain();
        n_tests++;
        if (err_seen != e0) begin
            n_fail++;
            $display("FAIL zero_err: %0d err pulses, required 0", err_seen - e0);
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < 522; i++) msg[i] = 10'd0;
        msg[521] = 10'd1;
        send_frame(1'b1, 1'b0);
        drain();
        for (int k = 0; k < 22; k++) begin
            n_tests++;
            if (last_rx[10+k] !== gfull[21-k]) begin
                n_fail++;
                $display("FAIL impulse_g%0d: got %h, required %h", 21 - k, last_rx[10+k], gfull[21-k]);
            end
        end
    endtask

    task automatic test_random_syndrome();
        int         nz;
        logic [9:0] s;
        logic [9:0] aj;
        logic [9:0] sym [544];
        rx_sym.delete();
        rx_en = 1'b1;
        for (int f = 0; f < 100; f++) begin
            rand_msg();
            send_frame(1'b1, 1'b0);
        end
        drain();
        rx_en = 1'b0;
        n_tests++;
        if (rx_sym.size() != 100*544) begin
            n_fail++;
            $display("FAIL rx_count: %0d symbols, required %0d", rx_sym.size(), 100*544);
        end
        for (int f = 0; f < 100 && rx_sym.size() >= 544; f++) begin
            for (int i = 0; i < 544; i++) sym[i] = rx_sym.pop_front();
            nz = 0;
            for (int j = 1; j <= 22; j++) begin
                aj = 10'(exp_t[j]);
                s  = 10'd0;
                for (int i = 0; i < 544; i++) s = gmul(s, aj) ^ sym[i];
                if (s != 10'd0) nz++;
            end
            n_tests++;
            if (nz != 0) begin
                n_fail++;
                $display("FAIL syndrome_cw%0d: %0d nonzero syndromes, required 0", f, nz);
            end
        end
    endtask

    task automatic test_backpressure();
        rdy_rand = 1'b1;
        for (int f = 0; f < 20; f++) begin
            rand_msg();
            send_frame(1'b1, 1'b0);
        end
        drain();
        rdy_rand = 1'b0;
    endtask

    task automatic test_sof_error();
        beat_t            e;
        logic [31:0][9:0] d;
        int               e0 = err_seen;
        rand_msg();
        make_cw();
        for (int b = 0; b < 7; b++) begin
            for (int l = 0; l < 32; l++) begin
                d[l]      = msg[32*b + l];
                e.data[l] = cw[32*b + l];
            end
            e.sof  = (b == 0);
            e.last = 1'b0;
            send_beat(d, b == 0, e);
        end
        rand_msg();
        send_frame(1'b1, 1'b1);
        drain();
        n_tests++;
        if (err_seen != e0 + 1) begin
            n_fail++;
            $display("FAIL sof_err_count: %0d pulses, required 1", err_seen - e0);
        end
    endtask

    task automatic test_missing_sof();
        rand_msg();
        send_frame(1'b0, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid();
        beat_t            e;
        logic [31:0][9:0] d;
        rand_msg();
        make_cw();
        for (int b = 0; b < 9; b++) begin
            for (int l = 0; l < 32; l++) begin
                d[l]      = msg[32*b + l];
                e.data[l] = cw[32*b + l];
            end
            e.sof  = (b == 0);
            e.last = 1'b0;
            send_beat(d, b == 0, e);
        end
        @(negedge clk);
        for (int l = 0; l < 32; l++) d[l] = msg[288 + l];
        valid_i = 1'b1;
        sof_i   = 1'b0;
        data_i  = d;
        rst_ni  = 1'b0;
        exp_q.delete();
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || sof_o !== 1'b0 || last_o !== 1'b0 || data_o !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: valid=%b sof=%b last=%b, required all cleared", valid_o, sof_o, last_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst_ni  = 1'b1;
        repeat (3) @(negedge clk);
        rand_msg();
        send_frame(1'b1, 1'b0);
        drain();
    endtask

    initial begin
        logic [10:0] x;
        x = 11'd1;
        for (int i = 0; i < 1023; i++) begin
            exp_t[i] = int'(x);
            log_t[x[9:0]] = i;
            x = x << 1;
            if (x[10]) x = x ^ 11'h409;
        end
        for (int i = 0; i < 23; i++) gfull[i] = 10'd0;
        gfull[0] = 10'd1;
        for (int j = 1; j <= 22; j++) begin
            for (int d = j; d >= 1; d--) gfull[d] = gfull[d-1] ^ gmul(gfull[d], 10'(exp_t[j]));
            gfull[0] = gmul(gfull[0], 10'(exp_t[j]));
        end

        test_reset();
        test_zero_frame();
        test_impulse();
        test_random_syndrome();
        test_backpressure();
        test_sof_error();
        test_missing_sof();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
